// File: rtl/debounce_edge.sv
// Debounce and edge-detect stage fed by the two-flop synchronizer: accepts a new
// level only after STABLE_CYCLES identical samples, then emits pulses and a rise count.
module debounce_edge #(
  parameter int STABLE_CYCLES = 4,
  parameter int COUNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   sync_in,
  input  logic                   clear,
  output logic                   level_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic [COUNT_WIDTH-1:0] event_count
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHECK_HIGH,
    IDLE_HIGH,
    CHECK_LOW
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [COUNT_WIDTH-1:0] count_q;

  // Entering a CHECK state counts the first matching sample, so a commit lands
  // STABLE_CYCLES-1 edges after the one that first saw the new level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (sync_in) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_W'(1);
          end
        end
        CHECK_HIGH: begin
          if (!sync_in) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            if (count_q != COUNT_MAX) begin
              count_q <= count_q + COUNT_WIDTH'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!sync_in) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_W'(1);
          end
        end
        CHECK_LOW: begin
          if (sync_in) begin
            state_q <= IDLE_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE_LOW;
          cnt_q   <= '0;
        end
      endcase
      // Clear overrides a same-edge rising commit; the pulse itself still fires.
      if (clear) begin
        count_q <= '0;
      end
    end
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign event_count = count_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: stimulus queues the expected commit,
// a negedge monitor pops and compares whenever a rise or fall pulse appears.
module tb_debounce_edge;

  localparam int STABLE = 4;
  localparam int CW     = 2;

  logic          clk;
  logic          n_rst;
  logic          sync_in;
  logic          clear;
  logic          level_out;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [CW-1:0] event_count;

  typedef struct {
    int commitEdge;
    int level;
    int rise;
    int fall;
    int count;
  } expect_t;

  expect_t expectQ[$];
  int      edgeNum    = 0;
  int      checkCount = 0;
  int      passCount  = 0;

  debounce_edge #(.STABLE_CYCLES(STABLE), .COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sync_in    (sync_in),
    .clear      (clear),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeNum <= edgeNum + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic value, input int cycles);
    sync_in = value;
    waitEdges(cycles);
  endtask

  // Queue a commit expected STABLE-1 edges after the next edge, then hold the level.
  task automatic expectCommit(input logic value, input int count);
    expect_t e;
    e.commitEdge = edgeNum + STABLE;
    e.level      = value;
    e.rise       = value;
    e.fall       = !value;
    e.count      = count;
    expectQ.push_back(e);
    applyStimulus(value, STABLE + 2);
  endtask

  always @(negedge clk) begin
    if (n_rst && (rise_pulse || fall_pulse)) begin
      expect_t e;
      checkOutput("pulsesExclusive", int'(rise_pulse && fall_pulse), 0);
      checkOutput("pulseWasExpected", int'(expectQ.size() > 0), 1);
      if (expectQ.size() > 0) begin
        e = expectQ.pop_front();
        checkOutput("commitEdge", edgeNum, e.commitEdge);
        checkOutput("risePulse", int'(rise_pulse), e.rise);
        checkOutput("fallPulse", int'(fall_pulse), e.fall);
        checkOutput("levelOut", int'(level_out), e.level);
        checkOutput("eventCount", int'(event_count), e.count);
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got 1, expected 0");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int satCounts[5] = '{1, 2, 3, 3, 3};
    n_rst   = 1'b0;
    sync_in = 1'b1;
    clear   = 1'b0;
    #1;
    checkOutput("resetLevel", int'(level_out), 0);
    checkOutput("resetRise", int'(rise_pulse), 0);
    checkOutput("resetFall", int'(fall_pulse), 0);
    checkOutput("resetCount", int'(event_count), 0);
    waitEdges(2);
    checkOutput("heldResetLevel", int'(level_out), 0);
    n_rst   = 1'b1;
    sync_in = 1'b0;
    waitEdges(3);
    checkOutput("postReleaseLevel", int'(level_out), 0);
    checkOutput("postReleaseCount", int'(event_count), 0);

    // Clean rise, then a 3-sample low glitch that must be ignored
    expectCommit(1'b1, 1);
    checkOutput("riseLevelHeld", int'(level_out), 1);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 4);
    checkOutput("glitchLevel", int'(level_out), 1);
    checkOutput("glitchCount", int'(event_count), 1);
    expectCommit(1'b0, 1);
    checkOutput("fallLevelHeld", int'(level_out), 0);

    // Saturation on a 2-bit counter
    clear = 1'b1;
    waitEdges(1);
    clear = 1'b0;
    checkOutput("clearedCount", int'(event_count), 0);
    for (int i = 0; i < 5; i++) begin
      expectCommit(1'b1, satCounts[i]);
      expectCommit(1'b0, satCounts[i]);
    end

    // Clear colliding with a rising commit at count 2
    clear = 1'b1;
    waitEdges(1);
    clear = 1'b0;
    expectCommit(1'b1, 1);
    expectCommit(1'b0, 1);
    expectCommit(1'b1, 2);
    expectCommit(1'b0, 2);
    begin
      expect_t e;
      e.commitEdge = edgeNum + STABLE;
      e.level = 1; e.rise = 1; e.fall = 0; e.count = 0;
      expectQ.push_back(e);
      sync_in = 1'b1;
      waitEdges(3);
      clear = 1'b1;
      waitEdges(1);
      clear = 1'b0;
      waitEdges(2);
    end
    checkOutput("collisionCount", int'(event_count), 0);
    expectCommit(1'b0, 0);
    expectCommit(1'b1, 1);
    expectCommit(1'b0, 1);

    // Reset in the middle of a high check discards the candidate
    applyStimulus(1'b1, 2);
    #1 n_rst = 1'b0;
    #1;
    checkOutput("midCheckResetLevel", int'(level_out), 0);
    checkOutput("midCheckResetCount", int'(event_count), 0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    expectCommit(1'b1, 1);

    waitEdges(4);
    checkOutput("scoreboardDrained", expectQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Debounce and edge-detect stage placed directly downstream of the two-flop input synchronizer. It consumes the synchronizer's `sync_out` and only accepts a new level once the input has held it for `STABLE_CYCLES` consecutive clock samples. It then produces a clean level, single-cycle rise/fall pulses and a saturating count of accepted rising edges for downstream control logic.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical samples required to accept a level change; legal range 2..255.
- `COUNT_WIDTH`, default 8: width of `event_count`; legal range ≥ 2.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `n_rst`  input  1: one clock; reset is asynchronous and active-low.
- `sync_in`  input  1: synchronized input level, driven by the synchronizer's `sync_out`.
- `clear`  input  1: synchronous clear of `event_count` only.
- `level_out`  output  1: debounced level, registered.
- `rise_pulse`  output  1: one-cycle pulse when a high level is accepted, registered.
- `fall_pulse`  output  1: one-cycle pulse when a low level is accepted, registered.
- `event_count`  output  COUNT_WIDTH: number of accepted rising edges, saturating, registered.

## Operation
- FSM states:
  - `IDLE_LOW`: accepted level 0.
  - `CHECK_HIGH`: candidate level 1.
  - `IDLE_HIGH`: accepted level 1.
  - `CHECK_LOW`: candidate level 0.
- Stability counter `cnt`: width ceil(log2(STABLE_CYCLES)); it is 0 in both IDLE states.
- `IDLE_LOW`:
  - `sync_in`=1 → `CHECK_HIGH`, `cnt`=1.
  - Otherwise stay.
- `CHECK_HIGH`:
  - `sync_in`=0 → `IDLE_LOW`, `cnt`=0, no pulse.
  - `sync_in`=1 and `cnt`=STABLE_CYCLES-1 → `IDLE_HIGH`, `cnt`=0, `level_out`←1, `rise_pulse`←1, `event_count` increments.
  - Otherwise `cnt`←`cnt`+1.
- `IDLE_HIGH` and `CHECK_LOW`: mirror of the above with polarity inverted; commit sets `level_out`←0 and `fall_pulse`←1. `event_count` is unchanged.
- `rise_pulse` and `fall_pulse` are 1 only in the cycle immediately following the commit edge; they return to 0 on the next edge. They are never asserted together.
- `event_count`:
  - Saturates at 2^COUNT_WIDTH-1; further rising commits leave it unchanged, while `rise_pulse` still fires.
  - `clear`=1 forces it to 0 on the next edge.
  - `clear` and a rising commit on the same edge → `event_count`=0; `rise_pulse` still asserts.
- A glitch shorter than STABLE_CYCLES samples produces no change on any output.
- `sync_in` is assumed clean 0/1; X handling is out of scope.

## Timing
- Reset (`n_rst`=0, asynchronous):
  - State `IDLE_LOW`, `cnt`=0.
  - `level_out`=0, `rise_pulse`=0, `fall_pulse`=0, `event_count`=0.
  - Outputs go to reset values without waiting for a clock edge.
- Reset asserted mid-CHECK: the candidate is discarded. After release the block needs a full STABLE_CYCLES samples of high before `level_out` rises.
- Reset release: the first sampling edge is the first rising `clk` after `n_rst` rises.
- Latency: `sync_in` changes before edge E0 and stays stable → commit at edge E0+(STABLE_CYCLES-1). `level_out` and the pulse are visible after that edge. Example: STABLE_CYCLES=4 → 3 edges after E0.
- End-to-end from the asynchronous pin: 2 synchronizer edges + STABLE_CYCLES-1 edges.
- `clear` takes effect on the edge where it is sampled high.
- Maximum accepted toggle rate: one commit per STABLE_CYCLES cycles.

## Test plan
- Reset: assert `n_rst`=0 with `sync_in`=1 for 2 cycles → all outputs 0 immediately and held; release away from the edge → outputs remain 0.
- Clean rise (STABLE_CYCLES=4): `sync_in`=1 before E0 and held → `level_out`=1 and `rise_pulse`=1 after E3, `rise_pulse`=0 after E4, `event_count`=1.
- Glitch reject: with `level_out`=1, drive `sync_in`=0 for 3 cycles then 1 → `level_out` stays 1, no `fall_pulse`, `event_count` unchanged. Next, 0 for 4 cycles → `fall_pulse` for one cycle, `level_out`=0.
- Saturation (COUNT_WIDTH=2): 5 accepted rising edges → `event_count` 1,2,3,3,3; `rise_pulse` fires all 5 times.
- Clear collision: assert `clear` on the same edge as a rising commit with `event_count`=2 → `event_count`=0, `rise_pulse`=1; next commit → 1.
- Reset mid-check: `sync_in`=1 for 2 cycles, pulse `n_rst` low, keep `sync_in`=1 → `level_out` rises exactly 3 edges after the first post-release edge.
